// File: rtl/ps2_drive_keys.sv
// PS/2 keyboard receiver and drive-key decoder: turns scan-code set 2 frames
// into mutually exclusive direction flags and a speed level.
module ps2_drive_keys #(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 50_000,
    parameter logic [3:0] SPEED_RESET    = 4'd5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       w,
    output logic       a,
    output logic       s,
    output logic       d,
    output logic       wa,
    output logic       wd,
    output logic       as,
    output logic       sd,
    output logic       stop,
    output logic [3:0] speed_level,
    output logic       key_event,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q, filt_prev_q;
    logic          fall;
    logic          dat_s;

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          clr_prefix_q, clr_prefix_d;

    logic          brk_q, ext_q;
    logic          kw_q, ka_q, ks_q, kd_q, ksp_q;
    logic [3:0]    speed_q, speed_out_q;
    logic [8:0]    flags_q, flags_d;

    assign dat_s = dat_sync_q[1];
    // Falling edge of the filtered clock is seen in the cycle after it drops.
    assign fall  = filt_prev_q & ~filt_clk_q;

    // Two-flop synchronisers; idle PS/2 lines are high.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
        end
    end

    // Glitch filter: accept a clock level only after FILTER_LEN differing samples.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_prev_q <= filt_clk_q;
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FMAX) begin
                filt_clk_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            clr_prefix_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            clr_prefix_q <= clr_prefix_d;
        end
    end

    // Receiver next-state: start, 8 data bits LSB first, odd parity, stop, plus idle timeout.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        clr_prefix_d = 1'b0;
        timer_d      = (state_q == ST_IDLE || fall) ? '0 : timer_q + TW'(1);
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (dat_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_ok_d = ^{shift_q, dat_s};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (dat_s && par_ok_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                        clr_prefix_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !fall && timer_q == TMAX) begin
            state_d      = ST_IDLE;
            frame_err_d  = 1'b1;
            clr_prefix_d = 1'b1;
        end
    end

    // Scan-code decoder: prefixes, held drive keys and speed selection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            kw_q    <= 1'b0;
            ka_q    <= 1'b0;
            ks_q    <= 1'b0;
            kd_q    <= 1'b0;
            ksp_q   <= 1'b0;
            speed_q <= SPEED_RESET;
        end else begin
            if (clr_prefix_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end
            if (byte_valid_q) begin
                if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (!ext_q) begin
                        case (shift_q)
                            8'h1D: kw_q  <= !brk_q;
                            8'h1C: ka_q  <= !brk_q;
                            8'h1B: ks_q  <= !brk_q;
                            8'h23: kd_q  <= !brk_q;
                            8'h29: ksp_q <= !brk_q;
                            8'h16: if (!brk_q) speed_q <= 4'd1;
                            8'h1E: if (!brk_q) speed_q <= 4'd2;
                            8'h26: if (!brk_q) speed_q <= 4'd3;
                            8'h25: if (!brk_q) speed_q <= 4'd4;
                            8'h2E: if (!brk_q) speed_q <= 4'd5;
                            8'h36: if (!brk_q) speed_q <= 4'd6;
                            8'h3D: if (!brk_q) speed_q <= 4'd7;
                            8'h3E: if (!brk_q) speed_q <= 4'd8;
                            8'h46: if (!brk_q) speed_q <= 4'd9;
                            8'h45: if (!brk_q) speed_q <= 4'd10;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Direction mapping; conflicting combinations leave every flag low.
    always_comb begin
        flags_d    = '0;
        flags_d[0] = ksp_q;
        if (!ksp_q) begin
            flags_d[8] = kw_q & !ka_q & !ks_q & !kd_q;
            flags_d[7] = ka_q & !kw_q & !ks_q & !kd_q;
            flags_d[6] = ks_q & !kw_q & !ka_q & !kd_q;
            flags_d[5] = kd_q & !kw_q & !ks_q & !ka_q;
            flags_d[4] = kw_q & ka_q & !ks_q & !kd_q;
            flags_d[3] = kw_q & kd_q & !ks_q & !ka_q;
            flags_d[2] = ks_q & ka_q & !kw_q & !kd_q;
            flags_d[1] = ks_q & kd_q & !kw_q & !ka_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            flags_q     <= '0;
            speed_out_q <= SPEED_RESET;
        end else begin
            flags_q     <= flags_d;
            speed_out_q <= speed_q;
        end
    end

    assign {w, a, s, d, wa, wd, as, sd, stop} = flags_q;
    assign speed_level = speed_out_q;
    assign key_event   = byte_valid_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_ps2_drive_keys.sv
// Directed bench for ps2_drive_keys: emulates a PS/2 keyboard and checks flags.
module tb_ps2_drive_keys;
    localparam int HALF = 15;
    localparam logic [8:0] F_W  = 9'h100, F_A  = 9'h080, F_S  = 9'h040, F_D    = 9'h020;
    localparam logic [8:0] F_WA = 9'h010, F_WD = 9'h008, F_AS = 9'h004, F_SD   = 9'h002;
    localparam logic [8:0] F_STOP = 9'h001, F_NONE = 9'h000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       w, a, s, d, wa, wd, as, sd, stop;
    logic [3:0] speed_level;
    logic       key_event, frame_err;
    logic [8:0] flags;

    int errors = 0;
    int checks = 0;
    int ke_cnt = 0;
    int fe_cnt = 0;
    int ke0, fe0;

    ps2_drive_keys dut (
        .CLOCK_50(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .w(w), .a(a), .s(s), .d(d), .wa(wa), .wd(wd), .as(as), .sd(sd), .stop(stop),
        .speed_level(speed_level), .key_event(key_event), .frame_err(frame_err)
    );

    always #10 clk = ~clk;
    assign flags = {w, a, s, d, wa, wd, as, sd, stop};

    always @(negedge clk) begin
        if (key_event) ke_cnt <= ke_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic pulse_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) pulse_bit(fr[i]);
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, 1'b0, 1'b0, 11);
        repeat (30) @(posedge clk);
    endtask

    task automatic release_key(input logic [7:0] b);
        send(8'hF0);
        send(b);
    endtask

    task automatic expect_state(input string tag, input logic [8:0] f, input logic [3:0] sp);
        @(negedge clk);
        check({tag, "_flags"}, flags, f);
        check({tag, "_speed"}, speed_level, sp);
    endtask

    initial begin
        bit found;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("rst_flags", flags, F_NONE);
        check("rst_speed", speed_level, 4'd5);
        check("rst_ke", ke_cnt, 0);
        check("rst_fe", fe_cnt, 0);

        // First make code with latency measured from key_event.
        ke0 = ke_cnt;
        found = 1'b0;
        fork
            send_raw(8'h1D, 1'b0, 1'b0, 11);
            begin
                for (int i = 0; i < 2000 && !found; i++) begin
                    @(negedge clk);
                    if (key_event) found = 1'b1;
                end
                check("ke_seen", found, 1'b1);
                if (found) begin
                    check("lat_t1", flags, F_NONE);
                    @(negedge clk);
                    check("ke_one_cycle", key_event, 1'b0);
                    check("lat_t2", flags, F_NONE);
                    @(negedge clk);
                    check("lat_t3", flags, F_W);
                end
            end
        join
        repeat (30) @(posedge clk);
        check("ke_count1", ke_cnt - ke0, 1);
        release_key(8'h1D);
        expect_state("brk_w", F_NONE, 4'd5);
        check("ke_count3", ke_cnt - ke0, 3);

        // Combinations and stop override.
        send(8'h1D); send(8'h1C);
        expect_state("wa", F_WA, 4'd5);
        send(8'h1D);
        expect_state("typematic", F_WA, 4'd5);
        send(8'h29);
        expect_state("stop", F_STOP, 4'd5);
        release_key(8'h29);
        expect_state("stop_rel", F_WA, 4'd5);
        send(8'h1B);
        expect_state("three_keys", F_NONE, 4'd5);
        release_key(8'h1B);
        release_key(8'h1D);
        expect_state("a_only", F_A, 4'd5);
        send(8'h1B);
        expect_state("as", F_AS, 4'd5);
        release_key(8'h1C);
        send(8'h23);
        expect_state("sd", F_SD, 4'd5);
        release_key(8'h1B);
        expect_state("d_only", F_D, 4'd5);
        send(8'h1D);
        expect_state("wd", F_WD, 4'd5);
        release_key(8'h1D);
        send(8'h1C);
        expect_state("a_d_conflict", F_NONE, 4'd5);
        release_key(8'h1C);
        release_key(8'h23);
        send(8'h1B);
        expect_state("s_only", F_S, 4'd5);
        release_key(8'h1B);

        // Speed keys.
        send(8'h26);
        expect_state("speed3", F_NONE, 4'd3);
        send(8'h45);
        expect_state("speed10", F_NONE, 4'd10);
        release_key(8'h45);
        expect_state("speed_brk", F_NONE, 4'd10);
        send(8'h16);
        expect_state("speed1", F_NONE, 4'd1);
        send(8'hE0); send(8'h1D);
        expect_state("ext_ignored", F_NONE, 4'd1);
        send(8'h1D);
        expect_state("after_ext", F_W, 4'd1);
        release_key(8'h1D);

        // Frame errors.
        ke0 = ke_cnt; fe0 = fe_cnt;
        send_raw(8'h1D, 1'b1, 1'b0, 11);
        repeat (30) @(posedge clk);
        check("par_fe", fe_cnt - fe0, 1);
        check("par_ke", ke_cnt - ke0, 0);
        expect_state("par_flags", F_NONE, 4'd1);
        send_raw(8'h1D, 1'b0, 1'b1, 11);
        repeat (30) @(posedge clk);
        check("stop_fe", fe_cnt - fe0, 2);
        pulse_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (30) @(posedge clk);
        check("start_fe", fe_cnt - fe0, 3);
        check("err_ke", ke_cnt - ke0, 0);

        // Timeout after 4 data bits also drops a pending break prefix.
        send(8'hF0);
        fe0 = fe_cnt;
        send_raw(8'h1D, 1'b0, 1'b0, 5);
        repeat (1000) @(posedge clk);
        check("to_early", fe_cnt - fe0, 0);
        repeat (49_200) @(posedge clk);
        check("to_fe", fe_cnt - fe0, 1);
        send(8'h1D);
        expect_state("after_to", F_W, 4'd1);

        // Reset in the middle of a frame while W is held.
        send(8'h26);
        expect_state("pre_rst", F_W, 4'd3);
        fe0 = fe_cnt;
        send_raw(8'h1C, 1'b0, 1'b0, 4);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_flags", flags, F_NONE);
        check("mid_rst_speed", speed_level, 4'd5);
        check("mid_rst_fe", frame_err, 1'b0);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        check("post_rst_fe", fe_cnt - fe0, 0);
        send(8'h1C);
        expect_state("post_rst_a", F_A, 4'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
